// File: rtl/xsim_dma_burst_initiator_pkg.sv
// Shared types and constants for the xsim DMA burst initiator.
package xsim_dma_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [3:0]  BYTEEN_ALL = 4'hF;
  localparam logic [31:0] RESET_FILL = 32'haaaaaaaa;

endpackage

// File: rtl/xsim_dma_burst_initiator_if.sv
// Responder-side bus between the burst initiator and the DPI-backed DMA model.
interface xsim_dma_burst_initiator_if;

  logic        dma_rdy_readrequest;
  logic        dma_en_readrequest;
  logic [31:0] dma_readrequest_addr;
  logic [31:0] dma_readrequest_handle;
  logic        dma_rdy_readresponse;
  logic        dma_en_readresponse;
  logic [31:0] dma_readresponse_data;
  logic        dma_en_write32;
  logic [31:0] dma_write32_addr;
  logic [31:0] dma_write32_handle;
  logic [31:0] dma_write32_data;
  logic [3:0]  dma_write32_byteenable;

  modport master (
    input  dma_rdy_readrequest,
    output dma_en_readrequest,
    output dma_readrequest_addr,
    output dma_readrequest_handle,
    input  dma_rdy_readresponse,
    output dma_en_readresponse,
    input  dma_readresponse_data,
    output dma_en_write32,
    output dma_write32_addr,
    output dma_write32_handle,
    output dma_write32_data,
    output dma_write32_byteenable
  );

  modport slave (
    output dma_rdy_readrequest,
    input  dma_en_readrequest,
    input  dma_readrequest_addr,
    input  dma_readrequest_handle,
    output dma_rdy_readresponse,
    input  dma_en_readresponse,
    output dma_readresponse_data,
    input  dma_en_write32,
    input  dma_write32_addr,
    input  dma_write32_handle,
    input  dma_write32_data,
    input  dma_write32_byteenable
  );

endinterface

// File: rtl/xsim_dma_burst_initiator_fifo.sv
// Synchronous read-data FIFO; flush empties it. Caller never pushes when full or pops when empty.
module xsim_dma_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       CLK,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge CLK) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/xsim_dma_burst_initiator.sv
// Converts word bursts into single-word DMA responder transactions; read data is buffered and streamed.
module xsim_dma_burst_initiator
  import xsim_dma_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LEN_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_handle,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_words,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [31:0]      rd_data,
  output logic             rd_last,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_byteen,
  output logic             done,
  xsim_dma_burst_initiator_if.master dma
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = CW + 1;

  state_t           state_q, state_d;
  logic [31:0]      handle_q;
  logic [31:0]      addr_q;
  logic [LEN_W-1:0] req_left;
  logic [LEN_W-1:0] beat_left;
  logic             outstanding;

  logic [CW-1:0]    fifo_count;
  logic             fifo_empty;
  logic [IW-1:0]    inflight;

  logic cmd_fire, req_issue, resp_take, rd_fire, wr_fire;

  assign inflight = {1'b0, fifo_count} + IW'(outstanding);

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    rd_valid  = 1'b0;
    rd_last   = 1'b0;
    done      = 1'b0;
    cmd_fire  = 1'b0;
    req_issue = 1'b0;
    resp_take = 1'b0;
    rd_fire   = 1'b0;
    wr_fire   = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        cmd_fire  = cmd_valid;
        if (cmd_valid) begin
          if (cmd_words == '0) state_d = DONE;
          else if (cmd_write)  state_d = WRITE;
          else                 state_d = READ;
        end
      end
      READ: begin
        // Credit uses registered occupancy only; the last term keeps a single request in flight
        // even if the responder has not yet answered the previous one.
        req_issue = (req_left != '0) && dma.dma_rdy_readrequest && (inflight < IW'(DEPTH))
                    && (!outstanding || dma.dma_rdy_readresponse);
        resp_take = outstanding && dma.dma_rdy_readresponse;
        rd_valid  = !fifo_empty;
        rd_last   = rd_valid && (beat_left == LEN_W'(1));
        rd_fire   = rd_valid && rd_ready;
        if (rd_fire && beat_left == LEN_W'(1)) state_d = DONE;
      end
      WRITE: begin
        wr_ready = 1'b1;
        wr_fire  = wr_valid;
        if (wr_fire && beat_left == LEN_W'(1)) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      handle_q    <= RESET_FILL;
      addr_q      <= RESET_FILL;
      req_left    <= '0;
      beat_left   <= '0;
      outstanding <= 1'b0;
    end else begin
      if (cmd_fire) begin
        handle_q  <= cmd_handle;
        addr_q    <= cmd_addr & ~32'(WORD_BYTES - 1);
        req_left  <= cmd_words;
        beat_left <= cmd_words;
      end
      if (req_issue || wr_fire) addr_q    <= addr_q + 32'(WORD_BYTES);
      if (req_issue)            req_left  <= req_left - LEN_W'(1);
      if (rd_fire || wr_fire)   beat_left <= beat_left - LEN_W'(1);
      if (req_issue)            outstanding <= 1'b1;
      else if (resp_take)       outstanding <= 1'b0;
    end
  end

  xsim_dma_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .CLK   (CLK),
    .flush (RST),
    .push  (resp_take),
    .pop   (rd_fire),
    .din   (dma.dma_readresponse_data),
    .head  (rd_data),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign dma.dma_en_readrequest     = req_issue;
  assign dma.dma_readrequest_addr   = addr_q;
  assign dma.dma_readrequest_handle = handle_q;
  assign dma.dma_en_readresponse    = resp_take;
  assign dma.dma_en_write32         = wr_fire;
  assign dma.dma_write32_addr       = addr_q;
  assign dma.dma_write32_handle     = handle_q;
  assign dma.dma_write32_data       = wr_data;
  assign dma.dma_write32_byteenable = wr_byteen;

endmodule
